conv_frame_scheduler: RTL and testbench

- Frame-level controller that feeds a KERNEL_SIZE x KERNEL_SIZE RGB convolution engine from a raster pixel stream.
- Holds the kernel configuration and builds sliding windows with line buffers. Issues one window per cycle to the engine, re-times engine results by its fixed latency, and saturates each result to an 8-bit output pixel.
- Output stream carries valid/ready backpressure, enforced through a credit scheme.
- Sits between the pixel source and the display/frame writer. The engine is an external instance.

---
 rtl/conv_frame_scheduler_pkg.sv | 27 ++
 rtl/conv_frame_scheduler_fifo.sv | 62 ++++++
 rtl/conv_frame_scheduler.sv | 175 +++++++++++++++++
 tb/tb_conv_frame_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg : shared widths, FSM states and result saturation for the
//            convolution frame scheduler
// Revision : 1.0
// ============================================================================
package conv_pkg;

  localparam int PIX_W = 96;
  localparam int CH_W  = 32;
  localparam int OUT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [OUT_W-1:0] clip8(input logic signed [CH_W-1:0] v);
    if (v < 0) return '0;
    if (v > 255) return '1;
    return v[OUT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_frame_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// conv_result_fifo : synchronous FIFO of {last, pix} results with occupancy
// Revision         : 1.0
// ============================================================================
module conv_result_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/conv_frame_scheduler.sv
`default_nettype none
// ============================================================================
// conv_frame_scheduler : raster stream to KxK window issue, engine re-timing,
//                        saturation and credit-controlled output stream
// Revision             : 1.0
// ============================================================================
module conv_frame_scheduler
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int ENGINE_LAT  = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic                                           k_wr,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]     k_addr,
  input  logic [PIX_W-1:0]                               k_data,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [PIX_W-1:0]                               in_pix,
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIX_W-1:0]       eng_kernel,
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIX_W-1:0]       eng_win,
  output logic                                           eng_win_valid,
  input  logic signed [CH_W-1:0]                         eng_res,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [OUT_W-1:0]                               out_pix,
  output logic                                           out_last,
  output logic                                           busy,
  output logic                                           frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int KK = K * K;
  localparam int AW = $clog2(KK);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int WW = KK * PIX_W;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  state_t                state;
  state_t                state_next;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [WW-1:0]         kern;
  logic [K*PIX_W-1:0]    col;
  logic [WW-1:0]         win;
  logic [WW-1:0]         win_next;
  logic                  issue_last;
  logic [ENGINE_LAT-1:0] vsr_valid;
  logic [ENGINE_LAT-1:0] vsr_last;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic [OUT_W:0]        fifo_dout;
  logic                  fifo_empty;
  logic                  accept;
  logic                  complete;
  logic                  frame_end;
  logic                  push;
  logic                  pop;

  assign accept    = in_valid && in_ready;
  assign complete  = (x >= XW'(K-1)) && (y >= YW'(K-1));
  assign frame_end = (x == XW'(IMG_W-1)) && (y == YW'(IMG_H-1));
  // Credit covers windows from acceptance until their result lands in the FIFO
  assign in_ready  = (state == RUN) &&
                     (({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_C);
  assign push      = vsr_valid[ENGINE_LAT-1];
  assign pop       = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign frame_done = (state == DONE);
  assign eng_kernel = kern;
  assign out_valid = !fifo_empty;
  assign {out_last, out_pix} = out_valid ? fifo_dout : '0;

  // Column row 0 is the incoming pixel; row r comes from the line r lines back
  assign col[PIX_W-1:0] = in_pix;
  for (genvar i = 0; i < K-1; i++) begin : g_lb
    logic [PIX_W-1:0] mem [IMG_W];
    always_ff @(posedge clk) begin
      if (accept) mem[x] <= col[i*PIX_W +: PIX_W];
    end
    assign col[(i+1)*PIX_W +: PIX_W] = mem[x];
  end

  // Tap r*K+c holds the pixel r rows up and c columns left of the newest one
  always_comb begin
    win_next = win;
    for (int r = 0; r < K; r++) begin
      for (int c = K-1; c > 0; c--)
        win_next[(r*K+c)*PIX_W +: PIX_W] = win[(r*K+c-1)*PIX_W +: PIX_W];
      win_next[r*K*PIX_W +: PIX_W] = col[r*PIX_W +: PIX_W];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) win <= win_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && frame_end) state_next = DRAIN;
      DRAIN:   if (inflight == '0 && fifo_count == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      kern          <= '0;
      eng_win       <= '0;
      eng_win_valid <= 1'b0;
      issue_last    <= 1'b0;
      vsr_valid     <= '0;
      vsr_last      <= '0;
      inflight      <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        x <= '0;
        y <= '0;
      end else if (accept) begin
        if (x == XW'(IMG_W-1)) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (state == IDLE && k_wr) begin
        for (int i = 0; i < KK; i++)
          if (k_addr == AW'(i)) kern[i*PIX_W +: PIX_W] <= k_data;
      end
      eng_win_valid <= accept && complete;
      if (accept && complete) begin
        eng_win    <= win_next;
        issue_last <= frame_end;
      end
      vsr_valid <= (vsr_valid << 1) | ENGINE_LAT'(eng_win_valid);
      vsr_last  <= (vsr_last << 1) | ENGINE_LAT'(eng_win_valid && issue_last);
      case ({accept && complete, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  conv_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (OUT_W+1)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({vsr_last[ENGINE_LAT-1], clip8(eng_res)}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_scheduler.sv
`default_nettype none
// ============================================================================
// tb_conv_frame_scheduler : directed frames against a spatial convolution model
// Revision                : 1.0
// ============================================================================
module tb_conv_frame_scheduler;

  localparam int K  = 3;
  localparam int KK = K * K;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int L  = 2;
  localparam int D  = 4;
  localparam int NOUT = (W-K+1) * (H-K+1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 k_wr;
  logic [3:0]           k_addr;
  logic [95:0]          k_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [95:0]          in_pix;
  logic [KK*96-1:0]     eng_kernel;
  logic [KK*96-1:0]     eng_win;
  logic                 eng_win_valid;
  logic signed [31:0]   eng_res;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_pix;
  logic                 out_last;
  logic                 busy;
  logic                 frame_done;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [8:0] exp_q [$];
  logic [8:0] exp_e;
  int         model_k [KK];
  int         got [16];
  int         n_got;
  int         done_cnt;
  int         done_cyc;
  int         last_pop_cyc;
  int         first_issue;
  int         first_out;
  logic signed [31:0] eng_pipe [L];

  conv_frame_scheduler #(
    .KERNEL_SIZE (K),
    .IMG_W       (W),
    .IMG_H       (H),
    .ENGINE_LAT  (L),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .k_wr          (k_wr),
    .k_addr        (k_addr),
    .k_data        (k_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pix        (in_pix),
    .eng_kernel    (eng_kernel),
    .eng_win       (eng_win),
    .eng_win_valid (eng_win_valid),
    .eng_res       (eng_res),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pix       (out_pix),
    .out_last      (out_last),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine: dot product over all taps and channels, L cycles after the window
  function automatic logic signed [31:0] dot(input logic [KK*96-1:0] kv, input logic [KK*96-1:0] wv);
    logic signed [31:0] acc;
    acc = 0;
    for (int i = 0; i < KK; i++)
      for (int ch = 0; ch < 3; ch++)
        acc += $signed(kv[i*96+ch*32 +: 32]) * $signed(wv[i*96+ch*32 +: 32]);
    return acc;
  endfunction

  always @(posedge clk) begin
    eng_pipe[0] <= dot(eng_kernel, eng_win);
    for (int i = 1; i < L; i++) eng_pipe[i] <= eng_pipe[i-1];
  end
  assign eng_res = eng_pipe[L-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic [7:0] clip_ref(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  // Red of pixel (x,y) is x+W*y; tap dy*K+dx weights the pixel dy up, dx left
  function automatic void build_expect();
    int acc;
    for (int oy = K-1; oy < H; oy++)
      for (int ox = K-1; ox < W; ox++) begin
        acc = 0;
        for (int dy = 0; dy < K; dy++)
          for (int dx = 0; dx < K; dx++)
            acc += model_k[dy*K+dx] * ((ox-dx) + W*(oy-dy));
        exp_q.push_back({(ox == W-1 && oy == H-1), clip_ref(acc)});
      end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (eng_win_valid && first_issue < 0) first_issue = cyc;
      if (out_valid && first_out < 0) first_out = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %0d, required none", out_pix);
        end else begin
          exp_e = exp_q.pop_front();
          check("out_pix", 64'(out_pix), 64'(exp_e[7:0]));
          check("out_last", 64'(out_last), 64'(exp_e[8]));
        end
        if (n_got < 16) got[n_got] = int'(out_pix);
        n_got++;
        if (out_last) last_pop_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dut.u_fifo.push && dut.u_fifo.full) begin
        failures++;
        $display("FAIL fifo_overflow: got push into full FIFO, required none");
      end
    end
  end

  task automatic load_taps(input int r);
    for (int i = 0; i < KK; i++) begin
      k_wr = 1'b1;
      k_addr = 4'(i);
      k_data = {32'(r), 64'd0};
      model_k[i] = r;
      @(posedge clk);
      #1;
    end
    k_wr = 1'b0;
  endtask

  task automatic send_pixels(input int n, input bit kwr_mid, output int sent);
    int  guard;
    bit  acc;
    sent = 0;
    guard = 0;
    while (sent < n && guard < 300) begin
      in_valid = 1'b1;
      in_pix = {32'(sent), 64'd0};
      if (kwr_mid && sent == 3) begin
        k_wr = 1'b1;
        k_addr = 4'd0;
        k_data = {32'd5, 64'd0};
      end else begin
        k_wr = 1'b0;
      end
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      guard++;
    end
    in_valid = 1'b0;
    k_wr = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit hold, input bit kwr_mid, input bit kwr_start,
                           input int l0, input int l1, input int l2, input int l3);
    int  sent;
    bit  seen;
    if (kwr_start) model_k[0] = 5;
    build_expect();
    n_got = 0;
    done_cnt = 0;
    first_issue = -1;
    first_out = -1;
    out_ready = !hold;
    start = 1'b1;
    if (kwr_start) begin
      k_wr = 1'b1;
      k_addr = 4'd0;
      k_data = {32'd5, 64'd0};
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    k_wr = 1'b0;
    send_pixels(W*H, kwr_mid, sent);
    check({tag, "_accepted"}, 64'(sent), 64'(W*H));
    if (hold) begin
      repeat (10) @(negedge clk);
      check({tag, "_held_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_held_out_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_held_fifo_count"}, 64'(dut.u_fifo.count), 64'(D));
      check({tag, "_held_no_done"}, 64'(done_cnt), 64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    check({tag, "_frame_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_after_last_pop"}, 64'((done_cyc - last_pop_cyc) >= 1 && (done_cyc - last_pop_cyc) <= 2), 64'd1);
    check({tag, "_issue_to_out"}, 64'(first_out - first_issue), 64'(L+1));
    check({tag, "_n_out"}, 64'(n_got), 64'(NOUT));
    check({tag, "_lit0"}, 64'(got[0]), 64'(l0));
    check({tag, "_lit1"}, 64'(got[1]), 64'(l1));
    check({tag, "_lit2"}, 64'(got[2]), 64'(l2));
    check({tag, "_lit3"}, 64'(got[3]), 64'(l3));
    check({tag, "_model_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int sent;
    reset = 1'b1;
    start = 1'b0;
    k_wr = 1'b0;
    k_addr = '0;
    k_data = '0;
    in_valid = 1'b0;
    in_pix = '0;
    out_ready = 1'b1;
    for (int i = 0; i < KK; i++) model_k[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pix", 64'(out_pix), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_eng_win_valid", 64'(eng_win_valid), 64'd0);
    check("rst_kernel_zero", 64'(eng_kernel == '0), 64'd1);
    check("rst_win_zero", 64'(eng_win == '0), 64'd1);
    @(posedge clk);
    #1;

    load_taps(1);
    run_frame("unit", 1'b0, 1'b0, 1'b0, 45, 54, 81, 90);
    load_taps(100);
    run_frame("sat_hi", 1'b0, 1'b0, 1'b0, 255, 255, 255, 255);
    load_taps(-1);
    run_frame("sat_lo", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    load_taps(1);
    run_frame("hold", 1'b1, 1'b0, 1'b0, 45, 54, 81, 90);
    run_frame("kwr_run", 1'b0, 1'b1, 1'b0, 45, 54, 81, 90);

    // Abort mid-frame with an asynchronous reset pulse
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_pixels(6, 1'b0, sent);
    check("abort_accepted", 64'(sent), 64'd6);
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < KK; i++) model_k[i] = 0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_kernel_zero", 64'(eng_kernel == '0), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    load_taps(1);
    run_frame("restart", 1'b0, 1'b0, 1'b0, 45, 54, 81, 90);
    run_frame("kwr_idle", 1'b0, 1'b0, 1'b1, 85, 98, 137, 150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
